aes_dec_top: RTL and testbench
==============================

# aes_dec_top

Iterative AES-128 decryption core, one round per clock: the inverse-direction counterpart of the team's AES-128 encryption core, with the same block/key port conventions. It accepts a 128-bit ciphertext and the original 128-bit cipher key and derives round key 10 internally. It then runs the inverse cipher while stepping the key schedule backwards. It sits beside the encryption core in the crypto datapath and returns the plaintext with a single-cycle valid pulse.

## Interface
- No parameters; fixed AES-128 with 10 rounds.
- clk  in  1  system clock, rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- data_v_i  in  1  request strobe; sampled only while ready_o=1.
- data_i  in  128  ciphertext. Byte 0 is at [127:120]; columns are words [127:96] (column 0) down to [31:0] (column 3), FIPS-197 order.
- key_i  in  128  cipher key, same byte order; sampled with data_v_i.
- ready_o  out  1  core idle; a request is accepted this cycle if data_v_i=1.
- res_v_o  out  1  one-cycle pulse; res_o holds valid plaintext.
- res_o  out  128  plaintext register; holds its value until the next accept.

## Operation
- Sub-blocks:
  - existing aes_sbox and aes_key_shedualing for the forward key step;
  - new aes_inv_sbox (16 instances) and aes_inv_mixw (4 instances, one per column).
- Inverse key step, rk_{i-1} from rk_i = {w0,w1,w2,w3} using rcon_i:
  - w3' = w3^w2, w2' = w2^w1, w1' = w1^w0;
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon_i,24'h0}.
  - Implemented locally with 4 aes_sbox instances.
- Rcon arithmetic, 8-bit GF(2^8):
  - forward step is xtime;
  - inverse step is (r>>1) ^ (r[0] ? 8'h8d : 8'h00).
- Registers: state_q, cnt_q[3:0], data_q[127:0], key_q[127:0], rcon_q[7:0], res_v_q.
- FSM states:
  - IDLE: ready_o=1. On data_v_i: data_q<=data_i, key_q<=key_i, rcon_q<=8'h01, cnt_q<=0, go to KEXP.
  - KEXP: key_q<=forward_step(key_q, rcon_q), rcon_q<=xtime(rcon_q), cnt_q++. After the step with cnt_q==9: rcon_q<=8'h36, cnt_q<=0, go to ADDK. key_q now holds rk10.
  - ADDK: data_q<=data_q^key_q, key_q<=inv_step(key_q, rcon_q), rcon_q<=inv_rcon(rcon_q), go to ROUND.
  - ROUND: data_q<=InvMixColumns(InvSubBytes(InvShiftRows(data_q))^key_q), key and rcon step back as in ADDK, cnt_q++. After cnt_q==8 (9 rounds, rk9..rk1), go to FINAL.
  - FINAL: data_q<=InvSubBytes(InvShiftRows(data_q))^key_q (key_q = rk0), res_v_q<=1, go to IDLE.
- InvShiftRows: row r rotates right by r bytes. Row 1 {b1,b5,b9,b13} becomes {b13,b1,b5,b9}.
- res_v_q clears on the next edge unconditionally.
- res_o = data_q.
- ready_o = (state_q==IDLE).

## Timing
- Reset values:
  - state IDLE; ready_o=1, res_v_o=0, res_o=128'h0;
  - cnt_q=0, rcon_q=0; key_q is don't-care.
- Accept at rising edge T (data_v_i=1, ready_o=1):
  - KEXP edges T+1..T+10;
  - ADDK at T+11;
  - ROUND at T+12..T+20;
  - FINAL at T+21.
- After edge T+21: res_v_o=1 and ready_o=1 for one cycle. Latency is 21 cycles; throughput is one block per 21 cycles.
- Back-to-back: data_v_i high in the res_v_o cycle is accepted. res_o shows the previous plaintext in that cycle and is overwritten at the next edge.
- data_v_i while ready_o=0 is ignored with no side effects. data_i and key_i are don't-care after the accept edge.
- reset=1 mid-operation: at the next edge, return to the reset values and abandon the block; no res_v_o pulse.
- reset and data_v_i together: reset wins.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a -> res_o 00112233445566778899aabbccddeeff, res_v_o pulse exactly 21 cycles after accept, width 1.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 -> internal key_q = d014f9a8c9ee2589e13f0cc8b6630ca6 on entering ADDK; res_o 3243f6a8885a308d313198a2e0370734.
- Two back-to-back blocks, the second data_v_i in the res_v_o cycle -> both plaintexts correct, pulses 21 cycles apart.
- data_v_i held high and data_i/key_i randomised during a block -> only the first request is processed, result matches C.1, ready_o stays 0 for 21 cycles.
- reset at cycle T+15 -> next cycle ready_o=1, res_v_o=0, res_o=0. A fresh C.1 request then decrypts correctly.
- Cross-check: 1000 random key/plaintext pairs through the encryption core, then through this block -> recovered plaintext matches in every case.

Source files
------------

// File: rtl/aes_dec_top.sv
// Iterative AES-128 decryptor: expands the cipher key forward to rk10, then runs the inverse cipher one round per clock.
// Latency 21 cycles from the accept edge to res_v_o; one block in flight at a time.
// Backpressure: ready_o is low while busy, and data_v_i is ignored then; res_v_o is a single-cycle pulse with no stall.
module aes_dec_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         data_v_i,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic         ready_o,
    output logic         res_v_o,
    output logic [127:0] res_o
);

    typedef enum logic [2:0] {IDLE, KEXP, ADDK, ROUND, FINAL} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         res_v_q, res_v_d;

    logic [127:0] isr, isb, ark, imc;
    logic [127:0] key_fwd, key_inv;
    logic [31:0]  iw1, iw2, iw3, rot_w, sub_w;
    logic [7:0]   rcon_fwd, rcon_inv;

    // InvShiftRows: byte k sits at row k%4, column k/4; row r rotates right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int R   = gi % 4;
        localparam int C   = gi / 4;
        localparam int SRC = R + 4 * ((C - R + 4) % 4);
        assign isr[127-8*gi -: 8] = data_q[127-8*SRC -: 8];
        aes_inv_sbox u_isb (.in_byte(isr[127-8*gi -: 8]), .out_byte(isb[127-8*gi -: 8]));
    end

    // Round key is added before InvMixColumns; the final round uses ark directly.
    assign ark = isb ^ key_q;

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        aes_inv_mixw u_imc (.col(ark[127-32*gc -: 32]), .mixed(imc[127-32*gc -: 32]));
    end

    // Forward key step, used only while expanding up to rk10.
    aes_key_shedualing u_kfwd (.key(key_q), .rcon(rcon_q), .next_key(key_fwd));

    // Backward key step: undo the xor chain, then recover w0 via SubWord(RotWord(w3')).
    assign iw3   = key_q[31:0]  ^ key_q[63:32];
    assign iw2   = key_q[63:32] ^ key_q[95:64];
    assign iw1   = key_q[95:64] ^ key_q[127:96];
    assign rot_w = {iw3[23:0], iw3[31:24]};

    for (genvar gk = 0; gk < 4; gk++) begin : g_kinv
        aes_sbox u_ks (.in_byte(rot_w[31-8*gk -: 8]), .out_byte(sub_w[31-8*gk -: 8]));
    end

    assign key_inv  = {key_q[127:96] ^ sub_w ^ {rcon_q, 24'h0}, iw1, iw2, iw3};
    assign rcon_fwd = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    assign rcon_inv = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);

    // Next-state and next-register values for every phase of a block.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        res_v_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_v_i) begin
                    data_d  = data_i;
                    key_d   = key_i;
                    rcon_d  = 8'h01;
                    cnt_d   = 4'd0;
                    state_d = KEXP;
                end
            end
            KEXP: begin
                key_d  = key_fwd;
                rcon_d = rcon_fwd;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    rcon_d  = 8'h36;
                    cnt_d   = 4'd0;
                    state_d = ADDK;
                end
            end
            ADDK: begin
                data_d  = data_q ^ key_q;
                key_d   = key_inv;
                rcon_d  = rcon_inv;
                state_d = ROUND;
            end
            ROUND: begin
                data_d = imc;
                key_d  = key_inv;
                rcon_d = rcon_inv;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                data_d  = ark;
                res_v_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            data_q  <= 128'h0;
            key_q   <= 128'h0;
            rcon_q  <= 8'h00;
            res_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            res_v_q <= res_v_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign res_v_o = res_v_q;
    assign res_o   = data_q;

endmodule

// AES-128 forward key schedule step: rk_i from rk_{i-1} and rcon_i.
// Latency: combinational.
// Backpressure: none.
module aes_key_shedualing (
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);
    logic [31:0] rot_w, sub_w, w0, w1, w2, w3;

    assign rot_w = {key[23:0], key[31:24]};

    for (genvar gk = 0; gk < 4; gk++) begin : g_ks
        aes_sbox u_ks (.in_byte(rot_w[31-8*gk -: 8]), .out_byte(sub_w[31-8*gk -: 8]));
    end

    assign w0       = key[127:96] ^ sub_w ^ {rcon, 24'h0};
    assign w1       = key[95:64] ^ w0;
    assign w2       = key[63:32] ^ w1;
    assign w3       = key[31:0] ^ w2;
    assign next_key = {w0, w1, w2, w3};
endmodule

// Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, computed as a^254 (0 maps to 0).
// Latency: combinational.
// Backpressure: none.
module aes_gf_inv (
    input  logic [7:0] a,
    output logic [7:0] inv
);
    logic [7:0] sq, acc;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Square-and-multiply: accumulate a^2 * a^4 * ... * a^128 = a^254.
    always_comb begin
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        inv = acc;
    end
endmodule

// AES forward S-box: field inverse followed by the affine map.
// Latency: combinational.
// Backpressure: none.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    logic [7:0] b;

    aes_gf_inv u_inv (.a(in_byte), .inv(b));

    assign out_byte = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// AES inverse S-box: inverse affine map followed by the field inverse.
// Latency: combinational.
// Backpressure: none.
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    logic [7:0] s, t;

    assign s = in_byte;
    assign t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;

    aes_gf_inv u_inv (.a(t), .inv(out_byte));
endmodule

// InvMixColumns on one 32-bit column (row 0 in the top byte).
// Latency: combinational.
// Backpressure: none.
module aes_inv_mixw (
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    logic [7:0] a0, a1, a2, a3;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (9, b, d or e) via repeated xtime.
    function automatic logic [7:0] mulc(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] p, t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ t;
            t = xt(t);
        end
        return p;
    endfunction

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    assign mixed[31:24] = mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9);
    assign mixed[23:16] = mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd);
    assign mixed[15:8]  = mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb);
    assign mixed[7:0]   = mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he);
endmodule

// File: tb/tb_aes_dec_top.sv
// Bench for aes_dec_top: known-answer vectors plus random blocks encrypted by a behavioural AES model.
// Latency: expects each result 21 cycles after its accept edge.
// Backpressure: requests are only issued when ready_o is high; held requests must be ignored while busy.
module tb_aes_dec_top;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_v_i;
    logic [127:0] data_i;
    logic [127:0] key_i;
    logic         ready_o;
    logic         res_v_o;
    logic [127:0] res_o;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    always #5 clk = ~clk;

    aes_dec_top dut (
        .clk      (clk),
        .reset    (reset),
        .data_v_i (data_v_i),
        .data_i   (data_i),
        .key_i    (key_i),
        .ready_o  (ready_o),
        .res_v_o  (res_v_o),
        .res_o    (res_o)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] exp_pt_q[$];
    int           exp_cyc_q[$];
    logic [7:0]   sbox[256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- behavioural AES-128 encryption model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w[44];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int k = 0; k < 16; k++) t[k] = s[(k%4) + 4*(((k/4) + (k%4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int k = 0; k < 16; k++) s[k] = t[k];
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) ct[127-8*k -: 8] = s[k];
        return ct;
    endfunction

    // ---------------- monitor: every result pulse pops one expectation ----------------
    logic [127:0] mon_pt;
    int           mon_due;
    always @(negedge clk) begin
        if (res_v_o === 1'b1) begin
            if (exp_pt_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: res_v_o=1 at cycle %0d, expected no pending block", cyc);
            end else begin
                mon_pt  = exp_pt_q.pop_front();
                mon_due = exp_cyc_q.pop_front();
                check("plaintext", res_o, mon_pt);
                check("pulse_cycle", 128'(cyc), 128'(mon_due));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                        input bit hold, input bit chk_rk);
        int w, n;
        w = 0;
        while (ready_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (ready_o !== 1'b1) begin
            check("ready_timeout", 128'(ready_o), 128'(1));
            return;
        end
        data_i   = ct;
        key_i    = key;
        data_v_i = 1'b1;
        exp_pt_q.push_back(pt);
        exp_cyc_q.push_back(cyc + 22);
        @(negedge clk);
        n = 1;
        while (ready_o !== 1'b1 && n < 60) begin
            if (chk_rk && n == 11) check("rk10_key_q", dut.key_q, B_RK10);
            if (hold) begin
                data_i = {$urandom, $urandom, $urandom, $urandom};
                key_i  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                data_v_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        data_v_i = 1'b0;
        check("busy_cycles", 128'(n - 1), 128'(21));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, key;
        int w;
        reset    = 1'b1;
        data_v_i = 1'b0;
        data_i   = '0;
        key_i    = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        check("reset_ready", 128'(ready_o), 128'(1));
        check("reset_res_v", 128'(res_v_o), 128'(0));
        check("reset_res", res_o, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        check("model_c1", aes_enc(C1_PT, C1_KEY), C1_CT);

        // Known answers, issued back-to-back.
        send(C1_CT, C1_KEY, C1_PT, 1'b0, 1'b0);
        send(B_CT, B_KEY, B_PT, 1'b0, 1'b1);
        // Request held high with garbage inputs while busy.
        send(C1_CT, C1_KEY, C1_PT, 1'b1, 1'b0);

        // Reset in the middle of a block abandons it.
        data_i   = C1_CT;
        key_i    = C1_KEY;
        data_v_i = 1'b1;
        @(negedge clk);
        data_v_i = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ready", 128'(ready_o), 128'(1));
        check("midreset_res_v", 128'(res_v_o), 128'(0));
        check("midreset_res", res_o, 128'h0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("midreset_idle", 128'(ready_o), 128'(1));

        // Reset wins over a simultaneous request.
        data_v_i = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        data_v_i = 1'b0;
        check("reset_vs_req_ready", 128'(ready_o), 128'(1));
        @(negedge clk);
        check("reset_vs_req_idle", 128'(ready_o), 128'(1));

        send(C1_CT, C1_KEY, C1_PT, 1'b0, 1'b0);

        // Random round trips through the encryption model.
        for (int i = 0; i < 1000; i++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            send(aes_enc(pt, key), key, pt, 1'b0, 1'b0);
        end

        w = 0;
        while (exp_pt_q.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("pending_results", 128'(exp_pt_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
